// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the 12-bit CPU ALU slice: datapath width, divider
// FSM encodings and the step counter sizing helper.
package cpu_alu_pkg;

    localparam int DATA_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int step_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int STEP_CNT_W = step_cnt_w(DATA_WIDTH);

endpackage

// File: rtl/cls_4_bit.sv
// 4-bit borrow-lookahead subtractor slice: {bout, d} = a - b - bin.
module cls_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] bw;

    // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
    assign g = ~a & b;
    assign p = ~(a ^ b);

    assign bw[0] = bin;
    assign bw[1] = g[0] | (p[0] & bin);
    assign bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & bin);
    assign bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d    = a ^ b ^ bw[3:0];
    assign bout = bw[4];

endmodule

// File: rtl/div_12_bit_seq.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per clock.
// Optional macro DIV_ZERO_DETECT_EN adds a one-edge divide-by-zero shortcut.
module div_12_bit_seq
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
`ifdef DIV_ZERO_DETECT_EN
    output logic             div_by_zero,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = step_cnt_w(WIDTH);
    localparam int NS = (WIDTH + 4) / 4;
    localparam int SW = NS * 4;

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
`ifdef DIV_ZERO_DETECT_EN
    logic             dz_q, dz_d;
`endif

    logic [WIDTH:0]   s_step;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] q_step;
    logic [SW-1:0]    sub_a, sub_b, sub_d;
    logic [NS:0]      bchain;
    logic             borrow;
    logic             unused_p_msb;

    assign s_step = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign sub_a  = SW'(s_step);
    assign sub_b  = SW'(dvsr_q);
    assign bchain[0] = 1'b0;

    for (genvar i = 0; i < NS; i++) begin : g_slice
        cls_4_bit u_slice (
            .a    (sub_a[4*i +: 4]),
            .b    (sub_b[4*i +: 4]),
            .bin  (bchain[i]),
            .d    (sub_d[4*i +: 4]),
            .bout (bchain[i+1])
        );
    end

    if (SW > WIDTH + 1) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^sub_d[SW-1:WIDTH+1];
    end

    // A kept difference is below the divisor, so the extra P bit stays zero.
    assign unused_p_msb = p_q[WIDTH];

    assign borrow = bchain[NS];
    assign p_step = borrow ? s_step : sub_d[WIDTH:0];
    assign q_step = {q_q[WIDTH-2:0], ~borrow};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    p_d     = '0;
                    q_d     = dividend;
                    dvsr_d  = divisor;
`ifdef DIV_ZERO_DETECT_EN
                    dz_d    = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                p_d   = p_step;
                q_d   = q_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    quot_d  = q_step;
                    rem_d   = p_step[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= dz_d;
`endif
        end
    end

    // Working registers are only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        p_q    <= p_d;
        q_q    <= q_d;
        dvsr_q <= dvsr_d;
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    assign div_by_zero = dz_q;
`endif

endmodule

// File: tb/tb_div_12_bit_seq.sv
// Directed-vector bench for div_12_bit_seq; follows DIV_ZERO_DETECT_EN if defined.
module tb_div_12_bit_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] dividend;
    logic [11:0] divisor;
    logic        busy;
    logic        done;
    logic [11:0] quotient;
    logic [11:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic        div_by_zero;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    div_12_bit_seq #(.WIDTH(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
`ifdef DIV_ZERO_DETECT_EN
        .div_by_zero (div_by_zero),
`endif
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [11:0] a, input logic [11:0] b, input bit hold);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Waits for done; optionally pulses a stray start after inj_step steps.
    task automatic wait_done(input int inj_step, output int lat, output int busy_n);
        bit seen;
        seen   = 1'b0;
        lat    = 0;
        busy_n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (busy) busy_n++;
            if (inj_step >= 0 && i == inj_step) begin
                start    = 1'b1;
                dividend = 12'd999;
                divisor  = 12'd3;
            end else if (inj_step >= 0 && i == inj_step + 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1'b1;
        end
        if (!seen) chk("timeout_done", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bn;
        int nd;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
`ifdef DIV_ZERO_DETECT_EN
        chk("rst_dz", div_by_zero, 0);
`endif
        rst = 1'b0;

        // 100 / 7
        start_op(12'd100, 12'd7, 1'b0);
        wait_done(-1, lat, bn);
        chk("t1_latency", lat, 12);
        chk("t1_busy_cycles", bn, 12);
        chk("t1_quot", quotient, 14);
        chk("t1_rem", remainder, 2);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", done, 0);
        chk("t1_quot_held", quotient, 14);

        // 0xFFF / 1
        start_op(12'hFFF, 12'd1, 1'b0);
        wait_done(-1, lat, bn);
        chk("t2a_quot", quotient, 12'hFFF);
        chk("t2a_rem", remainder, 0);

        // 37 / 0
        start_op(12'd37, 12'd0, 1'b0);
`ifdef DIV_ZERO_DETECT_EN
        chk("t3_done_fast", done, 1);
        chk("t3_busy", busy, 0);
        chk("t3_dz", div_by_zero, 1);
        chk("t3_quot", quotient, 12'hFFF);
        chk("t3_rem", remainder, 37);
        @(posedge clk);
        #1;
        chk("t3_done_pulse", done, 0);
        chk("t3_dz_held", div_by_zero, 1);
`else
        wait_done(-1, lat, bn);
        chk("t3_latency", lat, 12);
        chk("t3_quot", quotient, 12'hFFF);
        chk("t3_rem", remainder, 37);
`endif

        // 5 / 9
        start_op(12'd5, 12'd9, 1'b0);
`ifdef DIV_ZERO_DETECT_EN
        chk("t2b_dz_clear", div_by_zero, 0);
`endif
        wait_done(-1, lat, bn);
        chk("t2b_quot", quotient, 0);
        chk("t2b_rem", remainder, 5);

        // stray start at step 5 is ignored
        start_op(12'd1234, 12'd17, 1'b0);
        wait_done(5, lat, bn);
        chk("t4_latency", lat, 12);
        chk("t4_quot", quotient, 72);
        chk("t4_rem", remainder, 10);
        nd = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("t4_extra_done", nd, 0);
        chk("t4_quot_held", quotient, 72);

        // reset during step 6
        start_op(12'd500, 12'd7, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_quot", quotient, 0);
        chk("t5_rem", remainder, 0);
        nd = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done || busy) nd++;
        end
        chk("t5_no_done", nd, 0);
        start_op(12'd200, 12'd13, 1'b0);
        wait_done(-1, lat, bn);
        chk("t5_quot", quotient, 15);
        chk("t5_rem", remainder, 5);

        // back-to-back with start held through DONE
        start_op(12'd2048, 12'd3, 1'b1);
        wait_done(-1, lat, bn);
        chk("t6a_latency", lat, 12);
        chk("t6a_quot", quotient, 682);
        chk("t6a_rem", remainder, 2);
        dividend = 12'd4095;
        divisor  = 12'd64;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t6_b2b_busy", busy, 1);
        chk("t6_first_held", quotient, 682);
        wait_done(-1, lat, bn);
        chk("t6b_latency", lat, 12);
        chk("t6b_quot", quotient, 63);
        chk("t6b_rem", remainder, 63);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
